reg_share_arbiter: RTL and testbench
====================================

# reg_share_arbiter

Round-robin arbiter that shares one W-bit register (a bank of single-bit DFF cells on common `clk`/`rst`) among NREQ requesters. It grants one requester at a time, captures that requester's data into the shared register, then holds the value for a programmable settle interval before accepting the next write. It sits between the requester ports and the shared register; it is the only writer of that register.

## Interface
- NREQ, 4: number of requesters; legal range is 2 to 16.
- W, 8: width of the shared register.
- HOLD_CYCLES, 2: settle cycles after each write; legal range is 0 to 255.
- IDW, $clog2(NREQ): width of the requester ID (derived; not overridden).

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester write request, level-sensitive.
- wdata  in  NREQ*W  requester i's data is slice [i*W +: W].
- gnt  out  NREQ  one-hot grant, registered; high for exactly one cycle per grant.
- dout  out  W  shared register contents.
- upd  out  1  one-cycle pulse in the first cycle `dout` shows newly written data.
- last_id  out  IDW  ID of the requester that produced the current `dout`.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- State machine states:
  - IDLE: if any `req` bit is set, compute the round-robin winner and go to GRANT, with `gnt` set one-hot to the winner. Otherwise stay in IDLE.
  - GRANT: lasts exactly one cycle. The winner's `wdata` slice is sampled on the closing edge, which also performs these updates:
    - `dout` <= sampled data.
    - `upd` <= 1.
    - `last_id` <= winner.
    - `ptr` <= (winner+1) mod NREQ.
    - `gnt` <= 0.
    - Next state is HOLD if HOLD_CYCLES>0, otherwise IDLE.
  - HOLD: a down-counter is loaded with HOLD_CYCLES-1 on entry. The block returns to IDLE on the edge where the counter is 0. `req` is ignored while in HOLD.
- Round-robin priority order is `ptr`, `ptr`+1, …, `ptr`+NREQ-1 (mod NREQ); the first set bit in that order wins. `ptr` changes only on a completed write.
- Winner selection is combinational from `req` during IDLE. `gnt` is registered from that selection.
- If the winner drops `req` during GRANT, the write still completes. Requesters must hold `wdata` valid during their `gnt` cycle.
- `dout` changes only on the closing edge of GRANT or on reset. It holds its value in all other states.
- At most one `gnt` bit is set at any time; `gnt` is never set outside GRANT.
- Reset (sync, any state, including mid-GRANT or mid-HOLD) sets: state=IDLE, `gnt`=0, `dout`=0, `upd`=0, `last_id`=0, `ptr`=0, hold counter=0, `busy`=0. A grant in flight is abandoned and no write occurs.
- Reset has priority over every other event in the same cycle.

## Timing
- Cycle counting: `req` is seen in IDLE at cycle n.
  - `gnt` is high at cycle n+1 (1-cycle grant latency).
  - `dout`, `upd` and `last_id` update at cycle n+2 (2-cycle write latency).
  - HOLD occupies cycles n+2 … n+1+HOLD_CYCLES.
  - IDLE is reached at cycle n+2+HOLD_CYCLES.
- Minimum spacing between grants is 2+HOLD_CYCLES cycles. With HOLD_CYCLES=0, grants are spaced 2 cycles apart.
- `busy` is high from cycle n+1 through the last HOLD cycle.
- `upd` is high for exactly 1 cycle per completed write.

## Test plan
With NREQ=4, W=8, HOLD_CYCLES=2 unless stated otherwise:
1. Reset: hold `rst`=1 with `req`=4'b1111 for 3 cycles -> `gnt`=0, `dout`=0x00, `upd`=0, `busy`=0 throughout. Release `rst` -> first grant is to requester 0.
2. Single request: `req`=4'b0100 with wdata[2]=0xA5 at cycle 0 -> `gnt`=4'b0100 at cycle 1; `dout`=0xA5, `upd`=1, `last_id`=2 at cycle 2; `busy`=1 for cycles 1-3; IDLE at cycle 4.
3. Continuous contention: `req`=4'b1111 held, with wdata[i]=0x10+i -> grant order 0,1,2,3,0, one grant every 4 cycles; `dout` sequence 0x10, 0x11, 0x12, 0x13, 0x10.
4. Pointer wrap: after a grant to 3, `req`=4'b1001 -> the next grant goes to 0, not 3.
5. Reset mid-operation: assert `rst` in the GRANT cycle for requester 1 with wdata=0x3C -> `dout` stays 0x00, `upd` never pulses, `ptr`=0, and the next grant follows priority from 0.
6. HOLD_CYCLES=0, with `req`=4'b0011 held -> grants alternate 0,1,0,1 every 2 cycles; `req` asserted during GRANT is never granted in that same cycle.

Source files
------------

// File: rtl/reg_share_arbiter.sv
// rtl/reg_share_arbiter.sv - round-robin arbiter granting one writer at a time into a shared W-bit register
// Grants are registered, the write lands on the closing edge of GRANT, then HOLD settles for HOLD_CYCLES.
module reg_share_arbiter #(
  parameter int NREQ        = 4,
  parameter int W           = 8,
  parameter int HOLD_CYCLES = 2,
  localparam int IDW        = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] wdata,
  output logic [NREQ-1:0]   gnt,
  output logic [W-1:0]      dout,
  output logic              upd,
  output logic [IDW-1:0]    last_id,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, GRANT, HOLD} state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [W-1:0]    dout_q, dout_d;
  logic            upd_q, upd_d;
  logic [IDW-1:0]  last_id_q, last_id_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  win_q, win_d;
  logic [7:0]      cnt_q, cnt_d;

  logic [IDW-1:0]  rr_win;
  logic [IDW-1:0]  rr_idx;
  logic            rr_found;
  logic [W-1:0]    sel_data;

  // First requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    rr_win   = '0;
    rr_idx   = '0;
    rr_found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      rr_idx = IDW'((int'(ptr_q) + k) % NREQ);
      if (!rr_found && req[rr_idx]) begin
        rr_found = 1'b1;
        rr_win   = rr_idx;
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_q == IDW'(i)) sel_data = wdata[i*W +: W];
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = '0;
    dout_d    = dout_q;
    upd_d     = 1'b0;
    last_id_d = last_id_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (rr_found) begin
          state_d       = GRANT;
          gnt_d[rr_win] = 1'b1;
          win_d         = rr_win;
        end
      end
      GRANT: begin
        dout_d    = sel_data;
        upd_d     = 1'b1;
        last_id_d = win_q;
        ptr_d     = IDW'((int'(win_q) + 1) % NREQ);
        if (HOLD_CYCLES > 0) begin
          state_d = HOLD;
          cnt_d   = 8'(HOLD_CYCLES - 1);
        end else begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (cnt_q == 8'd0) state_d = IDLE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      dout_q    <= '0;
      upd_q     <= 1'b0;
      last_id_q <= '0;
      ptr_q     <= '0;
      win_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      dout_q    <= dout_d;
      upd_q     <= upd_d;
      last_id_q <= last_id_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      cnt_q     <= cnt_d;
    end
  end

  assign gnt     = gnt_q;
  assign dout    = dout_q;
  assign upd     = upd_q;
  assign last_id = last_id_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_reg_share_arbiter.sv
// tb/tb_reg_share_arbiter.sv - directed bench for reg_share_arbiter (HOLD_CYCLES=2 and HOLD_CYCLES=0 instances)
module tb_reg_share_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_a, req_b;
  logic [31:0] wdata_a, wdata_b;
  logic [3:0]  gnt_a, gnt_b;
  logic [7:0]  dout_a, dout_b;
  logic        upd_a, upd_b;
  logic [1:0]  last_id_a, last_id_b;
  logic        busy_a, busy_b;

  int total = 0;
  int bad   = 0;

  reg_share_arbiter #(.NREQ(4), .W(8), .HOLD_CYCLES(2)) u_dut_a (
    .clk(clk), .rst(rst), .req(req_a), .wdata(wdata_a), .gnt(gnt_a),
    .dout(dout_a), .upd(upd_a), .last_id(last_id_a), .busy(busy_a)
  );

  reg_share_arbiter #(.NREQ(4), .W(8), .HOLD_CYCLES(0)) u_dut_b (
    .clk(clk), .rst(rst), .req(req_b), .wdata(wdata_b), .gnt(gnt_b),
    .dout(dout_b), .upd(upd_b), .last_id(last_id_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst     = 1'b1;
    req_a   = 4'b1111;
    req_b   = 4'b0000;
    wdata_a = 32'h13121110;
    wdata_b = 32'h23222120;

    // Reset held with all requests asserted.
    for (int c = 0; c < 3; c++) begin
      step();
      chk("rst_gnt",  gnt_a,  0);
      chk("rst_dout", dout_a, 8'h00);
      chk("rst_upd",  upd_a,  0);
      chk("rst_busy", busy_a, 0);
    end
    rst = 1'b0;

    // Continuous contention: grants 0,1,2,3,0 every 4 cycles.
    for (int g = 0; g < 5; g++) begin
      step();
      chk("cont_gnt",  gnt_a,  32'(1) << (g % 4));
      chk("cont_busy", busy_a, 1);
      step();
      chk("cont_dout", dout_a, 8'h10 + (g % 4));
      chk("cont_upd",  upd_a,  1);
      chk("cont_id",   last_id_a, g % 4);
      chk("cont_gnt0", gnt_a,  0);
      step();
      chk("cont_upd0", upd_a,  0);
      chk("cont_hold", busy_a, 1);
      step();
      chk("cont_idle", busy_a, 0);
      if (g == 4) req_a = 4'b0000;
    end

    // Pointer wrap: grant 3, then 1001 goes to 0.
    req_a = 4'b1000;
    step();
    chk("wrap_gnt3", gnt_a, 4'b1000);
    req_a = 4'b1001;
    step();
    chk("wrap_id3", last_id_a, 3);
    chk("wrap_dout3", dout_a, 8'h13);
    step();
    step();
    chk("wrap_idle", busy_a, 0);
    step();
    chk("wrap_gnt0", gnt_a, 4'b0001);
    req_a = 4'b0000;
    step();
    chk("wrap_dout0", dout_a, 8'h10);
    step();
    step();
    chk("wrap_idle2", busy_a, 0);

    // Single request from 2, dropped during GRANT.
    wdata_a[23:16] = 8'hA5;
    req_a = 4'b0100;
    step();
    chk("single_gnt",  gnt_a,  4'b0100);
    chk("single_busy1", busy_a, 1);
    req_a = 4'b0000;
    step();
    chk("single_dout", dout_a, 8'hA5);
    chk("single_upd",  upd_a,  1);
    chk("single_id",   last_id_a, 2);
    chk("single_busy2", busy_a, 1);
    step();
    chk("single_busy3", busy_a, 1);
    chk("single_upd0",  upd_a,  0);
    step();
    chk("single_idle",  busy_a, 0);
    chk("single_keep",  dout_a, 8'hA5);

    // Reset during the GRANT cycle of requester 1.
    wdata_a[15:8] = 8'h3C;
    req_a = 4'b0010;
    step();
    chk("midrst_gnt", gnt_a, 4'b0010);
    rst = 1'b1;
    step();
    chk("midrst_dout", dout_a, 8'h00);
    chk("midrst_upd",  upd_a,  0);
    chk("midrst_gnt0", gnt_a,  0);
    chk("midrst_busy", busy_a, 0);
    chk("midrst_id",   last_id_a, 0);
    rst = 1'b0;
    req_a = 4'b1111;
    step();
    chk("midrst_next", gnt_a, 4'b0001);
    req_a = 4'b0000;
    step();
    chk("midrst_dout2", dout_a, 8'h10);

    // HOLD_CYCLES=0: 0011 held alternates 0,1 every 2 cycles.
    req_b = 4'b0011;
    for (int g = 0; g < 4; g++) begin
      step();
      chk("h0_gnt",  gnt_b, 32'(1) << (g % 2));
      step();
      chk("h0_gnt0", gnt_b, 0);
      chk("h0_upd",  upd_b, 1);
      chk("h0_id",   last_id_b, g % 2);
      chk("h0_dout", dout_b, 8'h20 + (g % 2));
    end
    req_b = 4'b0000;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
